// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch slice.
//   - bus widths for instruction addresses and instruction words
//   - chip-enable encodings, zero word, bubble instruction, reset PC
//   - ifid_ctrl_e: per-cycle command for the IF/ID pipeline register
package if_fetch_unit_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam inst_t       NOP_INST     = 32'h0000_0013;  // addi x0,x0,0
    localparam inst_addr_t  RESET_PC     = 32'h0000_0000;

    // What the IF/ID register does on the next edge.
    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_ctrl_e;

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst      : clock, synchronous active-high reset
//   ctrl          : load {pc_in, inst_in}, hold, or insert a bubble
//   pc_in/inst_in : fetch PC and the ROM word for it
//   id_pc/id_inst/id_valid : registered outputs to the ID stage
// A bubble carries NOP with PC zero and valid low, so ID never mistakes
// it for a real instruction.
module if_id_reg
    import if_fetch_unit_pkg::*;
#(
    parameter inst_t NOP = NOP_INST
) (
    input  logic       clk,
    input  logic       rst,
    input  ifid_ctrl_e ctrl,
    input  inst_addr_t pc_in,
    input  inst_t      inst_in,
    output inst_addr_t id_pc,
    output inst_t      id_inst,
    output logic       id_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc    <= ZERO_WORD;
            id_inst  <= NOP;
            id_valid <= 1'b0;
        end else begin
            case (ctrl)
                IFID_LOAD: begin
                    id_pc    <= pc_in;
                    id_inst  <= inst_in;
                    id_valid <= 1'b1;
                end
                IFID_HOLD: begin
                    id_pc    <= id_pc;
                    id_inst  <= id_inst;
                    id_valid <= id_valid;
                end
                default: begin
                    id_pc    <= ZERO_WORD;
                    id_inst  <= NOP;
                    id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: drives the combinational instruction ROM and
// fills the IF/ID register.
//   clk, rst              : clock, synchronous active-high reset
//   stall_if / stall_id   : hold PC / hold IF/ID (stall_id implies stall_if)
//   flush, new_pc         : trap redirect, wins over everything but reset
//   branch_flag_i/_target : redirect request from ID
//   inst_i                : ROM word for pc_o, valid in the same cycle
//   ce_o, pc_o            : ROM chip enable and address
//   id_pc_o/id_inst_o/id_valid_o : IF/ID register contents
//   misalign_o/_addr_o    : pulse and address of a rejected misaligned target
//
// Redirect handshake: branch_flag_i is a request with an implicit ready of
// (!stall_id && !flush). It is consumed only on an edge where that ready is
// high; otherwise it is dropped and ID is responsible for re-presenting it.
// An aligned request consumed while IF is stalled parks in the pending
// register and is applied on the first unstalled edge.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter inst_addr_t RESET_PC = if_fetch_unit_pkg::RESET_PC,
    parameter inst_t      NOP_INST = if_fetch_unit_pkg::NOP_INST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_if,
    input  logic       stall_id,
    input  logic       flush,
    input  inst_addr_t new_pc,
    input  logic       branch_flag_i,
    input  inst_addr_t branch_target_i,
    input  inst_t      inst_i,
    output logic       ce_o,
    output inst_addr_t pc_o,
    output inst_addr_t id_pc_o,
    output inst_t      id_inst_o,
    output logic       id_valid_o,
    output logic       misalign_o,
    output inst_addr_t misalign_addr_o
);

    logic       pend_valid;
    inst_addr_t pend_target;
    logic       stall_pc;
    logic       br_accept;
    logic       br_misaligned;
    logic       br_aligned;
    ifid_ctrl_e ifid_ctrl;

    // An ID stall without an IF stall is illegal; treat it as a full stall.
    assign stall_pc      = stall_if | stall_id;
    assign br_accept     = branch_flag_i & ~stall_id & ~flush;
    assign br_misaligned = br_accept & (branch_target_i[1:0] != 2'b00);
    assign br_aligned    = br_accept & (branch_target_i[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_o            <= CHIP_DISABLE;
            pc_o            <= RESET_PC;
            pend_valid      <= 1'b0;
            pend_target     <= ZERO_WORD;
            misalign_o      <= 1'b0;
            misalign_addr_o <= ZERO_WORD;
        end else begin
            ce_o       <= CHIP_ENABLE;
            misalign_o <= br_misaligned;
            if (br_misaligned) begin
                misalign_addr_o <= branch_target_i;
            end

            if (flush) begin
                pc_o       <= new_pc;
                pend_valid <= 1'b0;
            end else if (ce_o == CHIP_DISABLE) begin
                // First enabled cycle fetches RESET_PC itself.
                pc_o <= RESET_PC;
            end else if (stall_pc) begin
                if (br_aligned) begin
                    pend_valid  <= 1'b1;
                    pend_target <= branch_target_i;
                end
            end else if (br_aligned) begin
                pc_o       <= branch_target_i;
                pend_valid <= 1'b0;
            end else if (pend_valid) begin
                pc_o       <= pend_target;
                pend_valid <= 1'b0;
            end else begin
                pc_o <= pc_o + 32'd4;
            end
        end
    end

    // Anything fetched in a cycle that redirects is wrong-path, so it
    // becomes a bubble rather than being loaded.
    always_comb begin
        ifid_ctrl = IFID_LOAD;
        if (flush) begin
            ifid_ctrl = IFID_BUBBLE;
        end else if (stall_id) begin
            ifid_ctrl = IFID_HOLD;
        end else if (stall_if || br_accept || pend_valid || ce_o == CHIP_DISABLE) begin
            ifid_ctrl = IFID_BUBBLE;
        end
    end

    if_id_reg #(
        .NOP (NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (ifid_ctrl),
        .pc_in    (pc_o),
        .inst_in  (inst_i),
        .id_pc    (id_pc_o),
        .id_inst  (id_inst_o),
        .id_valid (id_valid_o)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(stall_id && !stall_if));
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          W   = 131;  // {ce, pc, id_pc, id_inst, valid, mis, mis_addr}

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] inst_i;
    logic        ce_o;
    logic [31:0] pc_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush           (flush),
        .new_pc          (new_pc),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .inst_i          (inst_i),
        .ce_o            (ce_o),
        .pc_o            (pc_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM model: distinct word per address, never NOP.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hA5A5_0001;
    endfunction
    assign inst_i = rom(pc_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop one expectation and compare it to the DUT outputs.
    task automatic score(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".ce"},       {31'd0, ce_o},       {31'd0, e[130]});
            check({tag, ".pc"},       pc_o,                e[129:98]);
            check({tag, ".id_pc"},    id_pc_o,             e[97:66]);
            check({tag, ".id_inst"},  id_inst_o,           e[65:34]);
            check({tag, ".id_valid"}, {31'd0, id_valid_o}, {31'd0, e[33]});
            check({tag, ".mis"},      {31'd0, misalign_o}, {31'd0, e[32]});
            check({tag, ".mis_addr"}, misalign_addr_o,     e[31:0]);
        end
    endtask

    // Driver: apply one cycle of inputs, queue the expected post-edge
    // state, clock it and score it.
    task automatic step(input string tag,
                        input logic r, input logic sif, input logic sid,
                        input logic fl, input logic [31:0] npc,
                        input logic br, input logic [31:0] tgt,
                        input logic e_ce, input logic [31:0] e_pc,
                        input logic [31:0] e_idpc, input logic [31:0] e_idinst,
                        input logic e_valid, input logic e_mis,
                        input logic [31:0] e_maddr);
        rst             = r;
        stall_if        = sif;
        stall_id        = sid;
        flush           = fl;
        new_pc          = npc;
        branch_flag_i   = br;
        branch_target_i = tgt;
        exp_q.push_back({e_ce, e_pc, e_idpc, e_idinst, e_valid, e_mis, e_maddr});
        @(posedge clk);
        #1;
        score(tag);
    endtask

    initial begin
        rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0;
        new_pc = '0; branch_flag_i = 1'b0; branch_target_i = '0;

        //    tag          rst sif sid fl npc            br tgt           ce pc            id_pc         id_inst            v  mis maddr
        step("reset0",     1, 0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        NOP,               0, 0, 32'h0);
        step("reset1",     1, 0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        NOP,               0, 0, 32'h0);
        step("ce_on",      0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        32'h0,        NOP,               0, 0, 32'h0);
        step("seq0",       0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4,        32'h0,        rom(32'h0),        1, 0, 32'h0);
        step("seq4",       0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h8,        32'h4,        rom(32'h4),        1, 0, 32'h0);
        step("br40",       0, 0, 0, 0, 32'h0,         1, 32'h40,       1, 32'h40,       32'h0,        NOP,               0, 0, 32'h0);
        step("after_br",   0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h44,       32'h40,       rom(32'h40),       1, 0, 32'h0);
        step("stall_br80", 0, 1, 0, 0, 32'h0,         1, 32'h80,       1, 32'h44,       32'h0,        NOP,               0, 0, 32'h0);
        step("stall2",     0, 1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h44,       32'h0,        NOP,               0, 0, 32'h0);
        step("pend_apply", 0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h80,       32'h0,        NOP,               0, 0, 32'h0);
        step("after_pend", 0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h84,       32'h80,       rom(32'h80),       1, 0, 32'h0);
        step("mis42",      0, 0, 0, 0, 32'h0,         1, 32'h42,       1, 32'h88,       32'h0,        NOP,               0, 1, 32'h42);
        step("after_mis",  0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h8C,       32'h88,       rom(32'h88),       1, 0, 32'h42);
        step("pend200",    0, 1, 0, 0, 32'h0,         1, 32'h200,      1, 32'h8C,       32'h0,        NOP,               0, 0, 32'h42);
        step("flush100",   0, 1, 1, 1, 32'h100,       1, 32'h40,       1, 32'h100,      32'h0,        NOP,               0, 0, 32'h42);
        step("pend_clr",   0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h104,      32'h100,      rom(32'h100),      1, 0, 32'h42);
        step("stall_id",   0, 1, 1, 0, 32'h0,         1, 32'h43,       1, 32'h104,      32'h100,      rom(32'h100),      1, 0, 32'h42);
        step("release",    0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h108,      32'h104,      rom(32'h104),      1, 0, 32'h42);
        step("pend_a",     0, 1, 0, 0, 32'h0,         1, 32'h200,      1, 32'h108,      32'h0,        NOP,               0, 0, 32'h42);
        step("pend_b",     0, 1, 0, 0, 32'h0,         1, 32'h300,      1, 32'h108,      32'h0,        NOP,               0, 0, 32'h42);
        step("pend_ovr",   0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h300,      32'h0,        NOP,               0, 0, 32'h42);
        step("after_ovr",  0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h304,      32'h300,      rom(32'h300),      1, 0, 32'h42);
        step("flush_f8",   0, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0,        1, 32'hFFFF_FFF8, 32'h0,       NOP,               0, 0, 32'h42);
        step("wrap_fc",    0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, rom(32'hFFFF_FFF8), 1, 0, 32'h42);
        step("wrap_0",     0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        32'hFFFF_FFFC, rom(32'hFFFF_FFFC), 1, 0, 32'h42);
        step("wrap_4",     0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4,        32'h0,        rom(32'h0),        1, 0, 32'h42);
        step("mis_f1",     0, 0, 0, 0, 32'h0,         1, 32'h51,       1, 32'h8,        32'h0,        NOP,               0, 1, 32'h51);
        step("mid_reset",  1, 0, 0, 0, 32'h0,         1, 32'h61,       0, 32'h0,        32'h0,        NOP,               0, 0, 32'h0);
        step("restart",    0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        32'h0,        NOP,               0, 0, 32'h0);
        step("restart0",   0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4,        32'h0,        rom(32'h0),        1, 0, 32'h0);

        // Report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Initiator side of the instruction-memory interface. Generates the fetch PC and chip enable for the combinational instruction ROM, which returns the instruction in the same cycle. Captures the {pc, inst} pair into the IF/ID pipeline register. Handles stalls, branch/jump redirects from ID (including redirects that arrive during an IF stall), exception flushes, and misaligned-target detection. Sits between the pipeline control unit, the ID stage and the instruction ROM.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted into IF/ID

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stall_if  in  1  hold PC (from control)
stall_id  in  1  hold IF/ID register; stall_id=1 implies stall_if=1
flush  in  1  exception/trap flush, highest priority after rst
new_pc  in  32  flush target
branch_flag_i  in  1  ID requests redirect
branch_target_i  in  32  redirect target
inst_i  in  32  instruction from ROM for current pc_o
ce_o  out  1  ROM chip enable (ChipEnable=1)
pc_o  out  32  ROM address / current fetch PC
id_pc_o  out  32  IF/ID PC
id_inst_o  out  32  IF/ID instruction
id_valid_o  out  1  IF/ID holds a real instruction
misalign_o  out  1  one-cycle pulse: rejected misaligned branch target
misalign_addr_o  out  32  offending target, held until next misalign

Behaviour:
- Reset: ce_o=0, pc_o=RESET_PC, id_pc_o=0, id_inst_o=NOP_INST, id_valid_o=0, misalign_o=0, misalign_addr_o=0, pending cleared. Mid-operation reset discards everything in the same edge.
- ce_o is registered. It goes to 1 on the first edge with rst=0. While ce_o=0, pc_o holds RESET_PC and IF/ID loads a bubble.
- ROM latency 0: inst_i is valid for pc_o in the same cycle; no retiming.
- Branch accept: branch_flag_i is sampled only when stall_id=0 and flush=0. With stall_id=1 it is ignored (ID re-presents it).
- Accepted target with target[1:0]!=0: no redirect; misalign_o=1 for one cycle; misalign_addr_o=target; IF/ID bubble; PC proceeds as if no branch.
- Pending redirect register (pend_valid, pend_target): an aligned branch accepted while stall_if=1 is latched. A second accept while pending overwrites it.
- PC next-state priority:
  1. rst
  2. flush: pc<=new_pc, pending cleared
  3. stall_if: hold
  4. accepted aligned branch: pc<=target
  5. pend_valid: pc<=pend_target, clear pending
  6. pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
- IF/ID next-state priority:
  1. rst
  2. flush: bubble
  3. stall_id: hold
  4. stall_if: bubble
  5. accepted branch (aligned or not): bubble, since the sequential fetch is wrong-path
  6. pend_valid: bubble
  7. ce_o=0: bubble
  8. otherwise load {pc_o, inst_i}, id_valid_o=1
- Bubble: id_inst_o=NOP_INST, id_pc_o=0, id_valid_o=0.
- Simultaneous flush + branch: flush wins; the branch is dropped and misalign_o is not raised.
- stall_id=1 with stall_if=0 is illegal: simulation assertion; RTL treats it as stall_if=1.

Decomposition:
- Shared package/defines: ZeroWord, ChipEnable/ChipDisable, InstAddrBus/InstBus widths, NOP_INST, RESET_PC.
- One natural sub-module: if_id_reg, the IF/ID register with hold/bubble/load control. PC logic and the pending register stay in the top.

Test Plan:
- Reset release with ROM 0:A,4:B: cycle0 ce_o=0; then pc_o=0,4,8 and IF/ID shows (0,A,valid), (4,B,valid), each one cycle after the fetch.
- Branch at pc_o=8, target 0x40, no stall -> next pc_o=0x40; IF/ID bubble (NOP_INST, valid=0); then (0x40, inst, valid).
- stall_if=1 for 2 cycles, stall_id=0, branch to 0x80 in first stall cycle -> pc_o held, two bubbles, pc_o=0x80 on the first cycle after the stall drops.
- Branch target 0x42 -> misalign_o=1 for one cycle, misalign_addr_o=0x42, pc continues +4, one bubble.
- flush with new_pc=0x100 together with branch 0x40 and stall_id=1 -> pc_o=0x100, IF/ID bubble, no misalign, pending cleared.
- Preload pc near 0xFFFF_FFF8 via flush -> pc_o sequence ...F8, ...FC, 0x0.
